// File: rtl/serial_cmd_pkg.sv
// Shared constants and FSM state type for the serial command parser.
// The S_CHK state exists only when SERIAL_CMD_CHECKSUM_EN is defined.
package serial_cmd_pkg;

  localparam logic [7:0] SOF_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_STOP  = 8'h02;

  localparam logic [1:0] ERR_CMD     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

`ifdef SERIAL_CMD_CHECKSUM_EN
  typedef enum logic [1:0] {S_SOF, S_CMD, S_PAYLOAD, S_CHK} state_e;
`else
  typedef enum logic [1:0] {S_SOF, S_CMD, S_PAYLOAD} state_e;
`endif

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle counter: clears on clr_i or when not running, saturates at
// TIMEOUT_CYCLES-1 and flags expire_o while sitting at that limit.
module idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !run_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    expire_d = (cnt_d == LIMIT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/serial_cmd_parser.sv
// Framed START/STOP command parser feeding the serial pattern output stage.
// Build option: define SERIAL_CMD_CHECKSUM_EN to require and verify a trailing XOR CHK byte.
module serial_cmd_parser
  import serial_cmd_pkg::*;
#(
  parameter int unsigned DATA_BIT       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_done_tick_i,
  input  logic                done_tick_i,
  output logic                start_o,
  output logic                stop_o,
  output logic                mode_o,
  output logic [DATA_BIT-1:0] output_pattern_o,
  output logic [DATA_BIT-1:0] freq_pattern_o,
  output logic [7:0]          slow_period_o,
  output logic [7:0]          fast_period_o,
  output logic                active_o,
  output logic                err_tick_o,
  output logic [1:0]          err_code_o
);

  localparam int unsigned NB    = DATA_BIT / 8;
  localparam int unsigned NP    = 3 + 2 * NB;
  localparam int unsigned IDX_W = $clog2(NP + 1);
  localparam int unsigned FW    = 2 * DATA_BIT + 16;
`ifdef SERIAL_CMD_CHECKSUM_EN
  localparam int unsigned NSTORE = NP;
`else
  localparam int unsigned NSTORE = NP - 1;
`endif
  localparam int unsigned SW = (NSTORE - 1) * 8;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic               stage_mode_q, stage_mode_d;
  logic [FW-1:0]      payload_c;
`ifdef SERIAL_CMD_CHECKSUM_EN
  logic [7:0]         chk_q, chk_d;
`endif

  logic               start_q, start_d, stop_q, stop_d;
  logic               mode_q, mode_d, active_q, active_d;
  logic [DATA_BIT-1:0] out_q, out_d, freq_q, freq_d;
  logic [7:0]         slow_q, slow_d, fast_q, fast_d;
  logic               err_tick_q, err_tick_d;
  logic [1:0]         err_code_q, err_code_d;

  logic commit_start, commit_stop;
  logic expire, run_c, timeout_c, last_c;

  assign run_c     = (state_q != S_SOF);
  assign timeout_c = expire && run_c && !rx_done_tick_i;
  assign last_c    = (idx_q == IDX_W'(NP - 1));

  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (run_c),
    .clr_i   (rx_done_tick_i),
    .expire_o(expire)
  );

  // Without a CHK byte the final payload byte commits straight from the input
`ifdef SERIAL_CMD_CHECKSUM_EN
  assign payload_c = stage_q;
`else
  assign payload_c = {rx_data_i, stage_q};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_SOF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_done_tick_i) begin
      case (state_q)
        S_SOF: if (rx_data_i == SOF_BYTE) state_d = S_CMD;
        S_CMD: begin
          if (rx_data_i == CMD_START) state_d = S_PAYLOAD;
`ifdef SERIAL_CMD_CHECKSUM_EN
          else if (rx_data_i == CMD_STOP) state_d = S_CHK;
`endif
          else state_d = S_SOF;
        end
        S_PAYLOAD: begin
`ifdef SERIAL_CMD_CHECKSUM_EN
          if (last_c) state_d = S_CHK;
`else
          if (last_c) state_d = S_SOF;
`endif
        end
        default: state_d = S_SOF;
      endcase
    end else if (timeout_c) begin
      state_d = S_SOF;
    end
  end

  always_comb begin
    idx_d        = idx_q;
    stage_d      = stage_q;
    stage_mode_d = stage_mode_q;
`ifdef SERIAL_CMD_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    commit_start = 1'b0;
    commit_stop  = 1'b0;
    err_tick_d   = 1'b0;
    err_code_d   = err_code_q;

    if (rx_done_tick_i) begin
      case (state_q)
        S_CMD: begin
          idx_d = '0;
`ifdef SERIAL_CMD_CHECKSUM_EN
          chk_d = rx_data_i;
`else
          commit_stop = (rx_data_i == CMD_STOP);
`endif
          if (rx_data_i != CMD_START && rx_data_i != CMD_STOP) begin
            err_tick_d = 1'b1;
            err_code_d = ERR_CMD;
          end
        end
        S_PAYLOAD: begin
          idx_d = idx_q + 1'b1;
          if (idx_q == '0) stage_mode_d = rx_data_i[0];
          for (int unsigned k = 1; k < NSTORE; k++) begin
            if (idx_q == IDX_W'(k)) stage_d[(k-1)*8 +: 8] = rx_data_i;
          end
`ifdef SERIAL_CMD_CHECKSUM_EN
          chk_d = chk_q ^ rx_data_i;
`else
          commit_start = last_c;
`endif
        end
`ifdef SERIAL_CMD_CHECKSUM_EN
        // idx_q only reaches NP after a full START payload; a STOP leaves it at 0
        S_CHK: begin
          if (rx_data_i == chk_q) begin
            commit_start = (idx_q == IDX_W'(NP));
            commit_stop  = (idx_q != IDX_W'(NP));
          end else begin
            err_tick_d = 1'b1;
            err_code_d = ERR_CHK;
          end
        end
`endif
        default: ;
      endcase
    end else if (timeout_c) begin
      err_tick_d = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end

    start_d  = commit_start;
    stop_d   = commit_stop;
    active_d = active_q;
    if (done_tick_i && !mode_q) active_d = 1'b0;
    if (commit_start)     active_d = 1'b1;
    else if (commit_stop) active_d = 1'b0;

    mode_d = commit_start ? stage_mode_q                       : mode_q;
    out_d  = commit_start ? payload_c[0 +: DATA_BIT]           : out_q;
    freq_d = commit_start ? payload_c[DATA_BIT +: DATA_BIT]    : freq_q;
    slow_d = commit_start ? payload_c[2*DATA_BIT +: 8]         : slow_q;
    fast_d = commit_start ? payload_c[2*DATA_BIT + 8 +: 8]     : fast_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q        <= '0;
      stage_q      <= '0;
      stage_mode_q <= 1'b0;
`ifdef SERIAL_CMD_CHECKSUM_EN
      chk_q        <= '0;
`endif
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      mode_q       <= 1'b0;
      active_q     <= 1'b0;
      out_q        <= '0;
      freq_q       <= '0;
      slow_q       <= '0;
      fast_q       <= '0;
      err_tick_q   <= 1'b0;
      err_code_q   <= '0;
    end else begin
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      stage_mode_q <= stage_mode_d;
`ifdef SERIAL_CMD_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
      start_q      <= start_d;
      stop_q       <= stop_d;
      mode_q       <= mode_d;
      active_q     <= active_d;
      out_q        <= out_d;
      freq_q       <= freq_d;
      slow_q       <= slow_d;
      fast_q       <= fast_d;
      err_tick_q   <= err_tick_d;
      err_code_q   <= err_code_d;
    end
  end

  assign start_o          = start_q;
  assign stop_o           = stop_q;
  assign mode_o           = mode_q;
  assign output_pattern_o = out_q;
  assign freq_pattern_o   = freq_q;
  assign slow_period_o    = slow_q;
  assign fast_period_o    = fast_q;
  assign active_o         = active_q;
  assign err_tick_o       = err_tick_q;
  assign err_code_o       = err_code_q;

endmodule

// File: tb/tb_serial_cmd_parser.sv
// Scoreboard bench for serial_cmd_parser: expected pulses are queued as frames
// are driven and matched by a negedge monitor; tasks also check held outputs.
module tb_serial_cmd_parser;

  localparam int unsigned DB = 32;
  localparam int unsigned TO = 40;

  logic          clk, rst, rx_tick, done_tick;
  logic [7:0]    rx_data;
  logic          start_o, stop_o, mode_o, active_o, err_tick_o;
  logic [DB-1:0] out_o, freq_o;
  logic [7:0]    slow_o, fast_o;
  logic [1:0]    err_code_o;

  serial_cmd_parser #(.DATA_BIT(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rx_data_i       (rx_data),
    .rx_done_tick_i  (rx_tick),
    .done_tick_i     (done_tick),
    .start_o         (start_o),
    .stop_o          (stop_o),
    .mode_o          (mode_o),
    .output_pattern_o(out_o),
    .freq_pattern_o  (freq_o),
    .slow_period_o   (slow_o),
    .fast_period_o   (fast_o),
    .active_o        (active_o),
    .err_tick_o      (err_tick_o),
    .err_code_o      (err_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    ev;   // {start, stop, err}
    logic [1:0]    code;
    logic          mode;
    logic [DB-1:0] outp;
    logic [DB-1:0] freq;
    logic [7:0]    slow;
    logic [7:0]    fast;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  logic          m_mode;
  logic [DB-1:0] m_out, m_freq;
  logic [7:0]    m_slow, m_fast;

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (start_o || stop_o || err_tick_o)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got start/stop/err=%b required none", {start_o, stop_o, err_tick_o});
      end else begin
        e = exp_q.pop_front();
        if ({start_o, stop_o, err_tick_o} !== e.ev) begin
          n_fail++;
          $display("FAIL event_kind: got %b required %b", {start_o, stop_o, err_tick_o}, e.ev);
        end else if (e.ev == 3'b100) begin
          n_cmp++;
          if ({mode_o, out_o, freq_o, slow_o, fast_o, active_o} !== {e.mode, e.outp, e.freq, e.slow, e.fast, 1'b1}) begin
            n_fail++;
            $display("FAIL start_fields: got %h required %h",
                     {mode_o, out_o, freq_o, slow_o, fast_o, active_o}, {e.mode, e.outp, e.freq, e.slow, e.fast, 1'b1});
          end
        end else if (e.ev == 3'b010) begin
          n_cmp++;
          if ({active_o, out_o, freq_o} !== {1'b0, e.outp, e.freq}) begin
            n_fail++;
            $display("FAIL stop_fields: got %h required %h", {active_o, out_o, freq_o}, {1'b0, e.outp, e.freq});
          end
        end else begin
          n_cmp++;
          if (err_code_o !== e.code) begin
            n_fail++;
            $display("FAIL err_code_event: got %0d required %0d", err_code_o, e.code);
          end
        end
      end
    end
  end

  task automatic push_start(input logic md, input logic [DB-1:0] op, input logic [DB-1:0] fq,
                            input logic [7:0] sl, input logic [7:0] fs);
    exp_t e;
    e.ev = 3'b100; e.code = 2'd0; e.mode = md; e.outp = op; e.freq = fq; e.slow = sl; e.fast = fs;
    exp_q.push_back(e);
    m_mode = md; m_out = op; m_freq = fq; m_slow = sl; m_fast = fs;
  endtask

  task automatic push_stop();
    exp_t e;
    e.ev = 3'b010; e.code = 2'd0; e.mode = m_mode; e.outp = m_out; e.freq = m_freq;
    e.slow = m_slow; e.fast = m_fast;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.ev = 3'b001; e.code = c; e.mode = 1'b0; e.outp = '0; e.freq = '0; e.slow = '0; e.fast = '0;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_tick = 1'b1;
  endtask

  task automatic end_bytes();
    @(negedge clk);
    rx_tick   = 1'b0;
    done_tick = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = 1'b0; m_out = '0; m_freq = '0; m_slow = '0; m_fast = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rx_tick = 1'b0; done_tick = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  // START frame; stall_after inserts an idle gap ending exactly at the timeout edge
  task automatic send_start(input logic [7:0] mode_b, input logic [DB-1:0] op, input logic [DB-1:0] fq,
                            input logic [7:0] sl, input logic [7:0] fs, input logic [7:0] chk_flip,
                            input int stall_after, input logic done_last);
    logic [7:0] fr[$];
    logic [7:0] x;
    fr = {};
    fr.push_back(8'hA5); fr.push_back(8'h01); fr.push_back(mode_b);
    for (int i = 0; i < DB / 8; i++) fr.push_back(op[i*8 +: 8]);
    for (int i = 0; i < DB / 8; i++) fr.push_back(fq[i*8 +: 8]);
    fr.push_back(sl); fr.push_back(fs);
    x = 8'h00;
    for (int i = 1; i < fr.size(); i++) x = x ^ fr[i];
`ifdef SERIAL_CMD_CHECKSUM_EN
    fr.push_back(x ^ chk_flip);
`endif
    if (chk_flip != 8'h00) push_err(2'd2);
    else push_start(mode_b[0], op, fq, sl, fs);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i]);
      if (done_last && i == fr.size() - 1) done_tick = 1'b1;
      if (i == stall_after) begin
        end_bytes();
        repeat (TO - 2) @(negedge clk);
      end
    end
  endtask

  task automatic send_stop();
    push_stop();
    send_byte(8'hA5);
    send_byte(8'h02);
`ifdef SERIAL_CMD_CHECKSUM_EN
    send_byte(8'h02);
`endif
  endtask

  task automatic pulse_done();
    @(negedge clk); done_tick = 1'b1;
    @(negedge clk); done_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_tick = 1'b0; done_tick = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({start_o, stop_o, err_tick_o} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b required 000", {start_o, stop_o, err_tick_o}); end
    n_cmp++; if (mode_o !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b required 0", mode_o); end
    n_cmp++; if (out_o !== '0) begin n_fail++; $display("FAIL reset_out: got %h required 0", out_o); end
    n_cmp++; if (freq_o !== '0) begin n_fail++; $display("FAIL reset_freq: got %h required 0", freq_o); end
    n_cmp++; if ({slow_o, fast_o} !== 16'h0) begin n_fail++; $display("FAIL reset_periods: got %h required 0", {slow_o, fast_o}); end
    n_cmp++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b required 0", active_o); end
    n_cmp++; if (err_code_o !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d required 0", err_code_o); end
  endtask

  task automatic test_start();
    logic [7:0] fr [14];
    fr = '{8'hA5, 8'h01, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h02, 8'h0F};
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    push_start(1'b1, 32'h12345678, 32'h0000000F, 8'd10, 8'd2);
`ifdef SERIAL_CMD_CHECKSUM_EN
    for (int i = 0; i < 14; i++) send_byte(fr[i]);
`else
    for (int i = 0; i < 13; i++) send_byte(fr[i]);
`endif
    end_bytes();
    @(negedge clk);
    n_cmp++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL start_one_cycle: got %b required 0", start_o); end
    n_cmp++; if (out_o !== 32'h12345678) begin n_fail++; $display("FAIL start_out: got %h required 12345678", out_o); end
    n_cmp++; if (freq_o !== 32'h0000000F) begin n_fail++; $display("FAIL start_freq: got %h required 0000000f", freq_o); end
    n_cmp++; if ({slow_o, fast_o} !== {8'd10, 8'd2}) begin n_fail++; $display("FAIL start_periods: got %h required 0a02", {slow_o, fast_o}); end
    n_cmp++; if ({mode_o, active_o} !== 2'b11) begin n_fail++; $display("FAIL start_mode_active: got %b required 11", {mode_o, active_o}); end
  endtask

  task automatic test_stop();
    send_stop();
    end_bytes();
    @(negedge clk);
    n_cmp++; if (stop_o !== 1'b0) begin n_fail++; $display("FAIL stop_one_cycle: got %b required 0", stop_o); end
    n_cmp++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL stop_active: got %b required 0", active_o); end
    n_cmp++; if ({out_o, slow_o} !== {32'h12345678, 8'd10}) begin n_fail++; $display("FAIL stop_hold: got %h required 123456780a", {out_o, slow_o}); end
  endtask

  task automatic test_bad_chk();
`ifdef SERIAL_CMD_CHECKSUM_EN
    apply_reset();
    send_start(8'h01, 32'h12345678, 32'h0000000F, 8'd10, 8'd2, 8'h01, -1, 1'b0);
    end_bytes();
    @(negedge clk);
    n_cmp++; if (err_code_o !== 2'd2) begin n_fail++; $display("FAIL chk_err_code: got %0d required 2", err_code_o); end
    n_cmp++; if ({out_o, freq_o} !== 64'h0) begin n_fail++; $display("FAIL chk_no_commit: got %h required 0", {out_o, freq_o}); end
    n_cmp++; if ({mode_o, active_o, slow_o, fast_o} !== 18'h0) begin n_fail++; $display("FAIL chk_no_commit_ctl: got %h required 0", {mode_o, active_o, slow_o, fast_o}); end
`endif
  endtask

  task automatic test_bad_cmd();
    push_err(2'd1);
    send_byte(8'hA5); send_byte(8'h07);
    end_bytes();
    n_cmp++; if (err_code_o !== 2'd1) begin n_fail++; $display("FAIL cmd_err_code: got %0d required 1", err_code_o); end
    send_stop();
    end_bytes();
    n_cmp++; if (err_code_o !== 2'd1) begin n_fail++; $display("FAIL cmd_err_hold: got %0d required 1", err_code_o); end
  endtask

  task automatic test_timeout();
    push_err(2'd3);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    end_bytes();
    repeat (TO - 1) @(negedge clk);
    n_cmp++; if (err_tick_o !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b required 0", err_tick_o); end
    @(negedge clk);
    n_cmp++; if ({err_tick_o, err_code_o} !== 3'b111) begin n_fail++; $display("FAIL timeout_err: got %b required 111", {err_tick_o, err_code_o}); end
    send_start({$urandom_range(0, 127), 1'b0}, $urandom, $urandom, 8'($urandom), 8'($urandom), 8'h00, -1, 1'b0);
    end_bytes();
    // byte lands on the same edge the idle counter expires
    send_start(8'h01, 32'hCAFEF00D, 32'h0F0F0F0F, 8'd7, 8'd3, 8'h00, 2, 1'b0);
    end_bytes();
    @(negedge clk);
    n_cmp++; if ({out_o, err_code_o} !== {32'hCAFEF00D, 2'd3}) begin n_fail++; $display("FAIL timeout_byte_wins: got %h required cafef00d3", {out_o, err_code_o}); end
  endtask

  task automatic test_done_tick();
    send_start(8'h00, 32'h1, 32'h2, 8'd3, 8'd4, 8'h00, -1, 1'b0);
    end_bytes();
    pulse_done();
    n_cmp++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL oneshot_done: got %b required 0", active_o); end
    send_start(8'h01, 32'h5, 32'h6, 8'd7, 8'd8, 8'h00, -1, 1'b0);
    end_bytes();
    pulse_done();
    n_cmp++; if (active_o !== 1'b1) begin n_fail++; $display("FAIL repeat_done: got %b required 1", active_o); end
    send_start(8'hFE, 32'h9, 32'hA, 8'd11, 8'd12, 8'h00, -1, 1'b0);
    end_bytes();
    n_cmp++; if (mode_o !== 1'b0) begin n_fail++; $display("FAIL mode_bit0_only: got %b required 0", mode_o); end
    send_start(8'h00, 32'hB, 32'hC, 8'd13, 8'd14, 8'h00, -1, 1'b1);
    end_bytes();
    @(negedge clk);
    n_cmp++; if (active_o !== 1'b1) begin n_fail++; $display("FAIL done_vs_commit: got %b required 1", active_o); end
  endtask

  task automatic test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pending_before_reset: got %0d required 0", exp_q.size()); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22);
    @(negedge clk);
    rx_tick = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({start_o, stop_o, err_tick_o, active_o, mode_o} !== 5'b0) begin n_fail++; $display("FAIL midreset_ctl: got %b required 0", {start_o, stop_o, err_tick_o, active_o, mode_o}); end
    n_cmp++; if ({out_o, freq_o, slow_o, fast_o, err_code_o} !== 82'h0) begin n_fail++; $display("FAIL midreset_data: got %h required 0", {out_o, freq_o, slow_o, fast_o, err_code_o}); end
    rst = 1'b0;
    model_reset();
    send_start(8'h01, 32'h87654321, 32'hFFFF0000, 8'd20, 8'd5, 8'h00, -1, 1'b0);
    end_bytes();
    @(negedge clk);
    n_cmp++; if (out_o !== 32'h87654321) begin n_fail++; $display("FAIL midreset_fresh: got %h required 87654321", out_o); end
  endtask

  task automatic test_back_to_back();
    send_stop();
    send_start(8'hA5, 32'hA5A5A5A5, 32'h00A500A5, 8'hA5, 8'h5A, 8'h00, -1, 1'b0);
    send_stop();
    end_bytes();
    @(negedge clk);
    n_cmp++; if ({out_o, freq_o} !== {32'hA5A5A5A5, 32'h00A500A5}) begin n_fail++; $display("FAIL b2b_patterns: got %h required a5a5a5a500a500a5", {out_o, freq_o}); end
    n_cmp++; if ({slow_o, fast_o, mode_o, active_o} !== {8'hA5, 8'h5A, 1'b1, 1'b0}) begin n_fail++; $display("FAIL b2b_ctl: got %h required %h", {slow_o, fast_o, mode_o, active_o}, {8'hA5, 8'h5A, 1'b1, 1'b0}); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop();
    test_bad_chk();
    test_bad_cmd();
    test_timeout();
    test_done_tick();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
